grf_wport_arbiter: RTL and testbench
====================================

GRF_WPORT_ARBITER -- requirements
Module: grf_wport_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, aux FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive cycles a pending aux head may lose before it is forced.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 iWB_WE / iWB_Addr / iWB_Data / iWB_PC8  in  1/5/32/32  pipeline writeback request, address, data, PC+8.
REQ-006 iAux_Valid / iAux_Addr / iAux_Data / iAux_PC8  in  1/5/32/32  multi-cycle unit write request (valid/ready push).
REQ-007 oAux_Ready  out  1  aux FIFO can accept this cycle.
REQ-008 oWE / oA3_Addr / oWD / oPC8  out  1/5/32/32  single register-file write port drive.
REQ-009 oWB_Hold  out  1  WB request not written this cycle; pipeline SHALL re-present it next cycle.
REQ-010 iQ1_Addr / iQ2_Addr  in  5/5  decode-stage source registers; oQ1_Busy / oQ2_Busy  out  1/1  source has a pending aux write.

Function
REQ-011 WB request counts only when iWB_WE=1 and iWB_Addr!=0; otherwise port is free for aux.
REQ-012 Aux push occurs when iAux_Valid && oAux_Ready; oAux_Ready = (count < DEPTH), from registered count only (no same-cycle pop credit).
REQ-013 Pushes with iAux_Addr==0 SHALL be accepted and dropped (no entry, no write).
REQ-014 Port selection, combinational each cycle, priority order: starved aux head, then WB request, then aux head, else idle (oWE=0, other outputs 0).
REQ-015 Aux head selected -> oWE=1, outputs = head fields, head popped at posedge.
REQ-016 WB selected -> oWE=1, outputs = WB fields; oWB_Hold=0.
REQ-017 oWB_Hold=1 exactly when a counted WB request exists and starved aux head is selected.
REQ-018 Latency: entry pushed in cycle N is written no earlier than cycle N+1; empty FIFO is never bypassed.
REQ-019 Starve counter: increments each cycle head is valid and not selected; clears on pop or when empty; saturates at STARVE_LIMIT; head is starved when counter == STARVE_LIMIT.
REQ-020 FIFO order preserved; pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-021 oQn_Busy=1 iff iQn_Addr!=0 and any valid FIFO entry, or the same-cycle accepted push, has that address.
REQ-022 Two aux entries to the same register SHALL both be written in push order.

Reset
REQ-023 On reset: FIFO empty, pointers and count 0, starve counter 0, oAux_Ready=1 from next cycle, oWE=0, oWB_Hold=0, oQn_Busy=0.
REQ-024 Reset mid-operation SHALL discard all buffered entries without writing them; an aux push in the reset cycle is discarded.

Configuration
REQ-025 With GRF_ARB_TRACE_EN defined, each cycle with oWE=1 and not reset SHALL $display "<time>@<oPC8-8>: $<addr> <= <data>" (hex PC/data, decimal addr).
REQ-026 Without GRF_ARB_TRACE_EN, no display statements are compiled; port behaviour identical.

Verification
REQ-027 Reset then WB write $5=0x1234, no aux -> oWE=1, oA3_Addr=5, oWD=0x1234 same cycle, oWB_Hold=0.
REQ-028 Push aux $8=0xAA in cycle N, WB idle -> oQ1_Busy=1 for iQ1_Addr=8 in N and N+1, write $8 in N+1, busy clears in N+2.
REQ-029 Push 4 aux entries with WB writing continuously (DEPTH=4) -> oAux_Ready=0 after 4th; 5th push held; entries drain in order once WB idles.
REQ-030 Aux head pending, WB writes every cycle, STARVE_LIMIT=8 -> 9th cycle aux written, oWB_Hold=1 that cycle, WB written the next cycle.
REQ-031 Aux push to $0 and WB write to $0 -> no oWE, FIFO count stays 0, aux drain not blocked.
REQ-032 Two entries buffered, assert reset for one cycle -> no write of either entry, count 0, oAux_Ready=1 afterward.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a buffered multi-cycle unit FIFO.
// Define GRF_ARB_TRACE_EN to print a per-write trace line in simulation.
module grf_wport_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iWB_WE,
  input  logic [4:0]  iWB_Addr,
  input  logic [31:0] iWB_Data,
  input  logic [31:0] iWB_PC8,
  input  logic        iAux_Valid,
  input  logic [4:0]  iAux_Addr,
  input  logic [31:0] iAux_Data,
  input  logic [31:0] iAux_PC8,
  output logic        oAux_Ready,
  output logic        oWE,
  output logic [4:0]  oA3_Addr,
  output logic [31:0] oWD,
  output logic [31:0] oPC8,
  output logic        oWB_Hold,
  input  logic [4:0]  iQ1_Addr,
  input  logic [4:0]  iQ2_Addr,
  output logic        oQ1_Busy,
  output logic        oQ2_Busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc8  [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic wb_req, head_valid, starved, accept, push, pop;
  logic q1_hit, q2_hit;
  logic [PW-1:0] off;

  assign wb_req     = iWB_WE && (iWB_Addr != 5'd0);
  assign head_valid = (count != '0);
  assign starved    = head_valid && (starve_cnt == SW'(STARVE_LIMIT));
  // Ready comes from the registered count only; a same-cycle pop gives no credit.
  assign oAux_Ready = (count < CW'(DEPTH));
  assign accept     = iAux_Valid && oAux_Ready;
  // Writes to $0 are accepted on the handshake but never buffered.
  assign push       = accept && (iAux_Addr != 5'd0);

  // Port selection: starved aux head, then WB, then aux head, else idle.
  always_comb begin
    oWE      = 1'b0;
    oA3_Addr = 5'd0;
    oWD      = 32'd0;
    oPC8     = 32'd0;
    oWB_Hold = 1'b0;
    pop      = 1'b0;
    if (!reset) begin
      if (starved) begin
        pop      = 1'b1;
        oWE      = 1'b1;
        oA3_Addr = mem_addr[rptr];
        oWD      = mem_data[rptr];
        oPC8     = mem_pc8[rptr];
        oWB_Hold = wb_req;
      end else if (wb_req) begin
        oWE      = 1'b1;
        oA3_Addr = iWB_Addr;
        oWD      = iWB_Data;
        oPC8     = iWB_PC8;
      end else if (head_valid) begin
        pop      = 1'b1;
        oWE      = 1'b1;
        oA3_Addr = mem_addr[rptr];
        oWD      = mem_data[rptr];
        oPC8     = mem_pc8[rptr];
      end
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    q1_hit = 1'b0;
    q2_hit = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr;
      if ({1'b0, off} < count) begin
        if (mem_addr[i] == iQ1_Addr) q1_hit = 1'b1;
        if (mem_addr[i] == iQ2_Addr) q2_hit = 1'b1;
      end
    end
  end

  assign oQ1_Busy = !reset && (iQ1_Addr != 5'd0) &&
                    (q1_hit || (push && (iAux_Addr == iQ1_Addr)));
  assign oQ2_Busy = !reset && (iQ2_Addr != 5'd0) &&
                    (q2_hit || (push && (iAux_Addr == iQ2_Addr)));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= iAux_Addr;
      mem_data[wptr] <= iAux_Data;
      mem_pc8[wptr]  <= iAux_PC8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (pop || !head_valid)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef GRF_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && oWE)
      $display("%0t@%h: $%0d <= %h", $time, oPC8 - 32'd8, oA3_Addr, oWD);
  end
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_grf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iWB_WE;
  logic [4:0]  iWB_Addr;
  logic [31:0] iWB_Data, iWB_PC8;
  logic        iAux_Valid;
  logic [4:0]  iAux_Addr;
  logic [31:0] iAux_Data, iAux_PC8;
  logic        oAux_Ready, oWE, oWB_Hold, oQ1_Busy, oQ2_Busy;
  logic [4:0]  oA3_Addr, iQ1_Addr, iQ2_Addr;
  logic [31:0] oWD, oPC8;

  int tests_run = 0;
  int tests_failed = 0;

  grf_wport_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .iWB_WE(iWB_WE), .iWB_Addr(iWB_Addr), .iWB_Data(iWB_Data), .iWB_PC8(iWB_PC8),
    .iAux_Valid(iAux_Valid), .iAux_Addr(iAux_Addr), .iAux_Data(iAux_Data), .iAux_PC8(iAux_PC8),
    .oAux_Ready(oAux_Ready), .oWE(oWE), .oA3_Addr(oA3_Addr), .oWD(oWD), .oPC8(oPC8),
    .oWB_Hold(oWB_Hold), .iQ1_Addr(iQ1_Addr), .iQ2_Addr(iQ2_Addr),
    .oQ1_Busy(oQ1_Busy), .oQ2_Busy(oQ2_Busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb_we, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                       input logic aux_v, input logic [4:0] aux_addr, input logic [31:0] aux_data);
    iWB_WE     = wb_we;
    iWB_Addr   = wb_addr;
    iWB_Data   = wb_data;
    iWB_PC8    = 32'h0000_1008;
    iAux_Valid = aux_v;
    iAux_Addr  = aux_addr;
    iAux_Data  = aux_data;
    iAux_PC8   = 32'h0000_2008;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Checks write-port outputs for the current cycle, sampled mid-cycle.
  task automatic expect_write(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] data);
    @(negedge clk);
    check_eq({tag, "_we"}, {31'd0, oWE}, {31'd0, we});
    check_eq({tag, "_addr"}, {27'd0, oA3_Addr}, {27'd0, addr});
    check_eq({tag, "_data"}, oWD, data);
  endtask

  initial begin
    reset = 1'b1;
    iQ1_Addr = 5'd0;
    iQ2_Addr = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_ready", {31'd0, oAux_Ready}, 32'd1);
    check_eq("rst_we", {31'd0, oWE}, 32'd0);
    check_eq("rst_hold", {31'd0, oWB_Hold}, 32'd0);
    iQ1_Addr = 5'd8;
    #1;
    check_eq("rst_busy", {31'd0, oQ1_Busy}, 32'd0);
    tick();

    // WB write passes straight through
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    expect_write("wb5", 1'b1, 5'd5, 32'h1234);
    check_eq("wb5_hold", {31'd0, oWB_Hold}, 32'd0);
    check_eq("wb5_pc8", oPC8, 32'h1008);
    tick();

    // Aux push, then write next cycle, busy spans both cycles
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hAA);
    expect_write("aux8_n", 1'b0, 5'd0, 32'd0);
    check_eq("aux8_busy_n", {31'd0, oQ1_Busy}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_write("aux8_n1", 1'b1, 5'd8, 32'hAA);
    check_eq("aux8_busy_n1", {31'd0, oQ1_Busy}, 32'd1);
    check_eq("aux8_pc8", oPC8, 32'h2008);
    tick();
    expect_write("aux8_n2", 1'b0, 5'd0, 32'd0);
    check_eq("aux8_busy_n2", {31'd0, oQ1_Busy}, 32'd0);
    tick();

    // Fill FIFO under continuous WB, hold a 5th push, drain in order
    do_reset();
    iQ2_Addr = 5'd14;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 32'h30 + i, 1'b1, 5'(10 + i), 32'h100 + i);
      expect_write($sformatf("fill%0d", i), 1'b1, 5'd3, 32'h30 + i);
      check_eq($sformatf("fill%0d_ready", i), {31'd0, oAux_Ready}, 32'd1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd3, 32'h40 + i, 1'b1, 5'd14, 32'h104);
      expect_write($sformatf("full%0d", i), 1'b1, 5'd3, 32'h40 + i);
      check_eq($sformatf("full%0d_ready", i), {31'd0, oAux_Ready}, 32'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h104);
    expect_write("drain0", 1'b1, 5'd10, 32'h100);
    check_eq("drain0_ready", {31'd0, oAux_Ready}, 32'd0);
    tick();
    expect_write("drain1", 1'b1, 5'd11, 32'h101);
    check_eq("drain1_ready", {31'd0, oAux_Ready}, 32'd1);
    check_eq("drain1_busy14", {31'd0, oQ2_Busy}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 2; i < 5; i++) begin
      expect_write($sformatf("drain%0d", i), 1'b1, 5'(10 + i), 32'h100 + i);
      tick();
    end
    expect_write("drain_end", 1'b0, 5'd0, 32'd0);
    check_eq("drain_end_busy14", {31'd0, oQ2_Busy}, 32'd0);
    tick();

    // Starvation: aux forced on the 9th losing cycle, WB held that cycle
    do_reset();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'hBB);
    expect_write("starve_push", 1'b1, 5'd4, 32'h44);
    tick();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      expect_write($sformatf("starve_wb%0d", i), 1'b1, 5'd4, 32'h44);
      check_eq($sformatf("starve_hold%0d", i), {31'd0, oWB_Hold}, 32'd0);
      tick();
    end
    expect_write("starve_forced", 1'b1, 5'd9, 32'hBB);
    check_eq("starve_forced_hold", {31'd0, oWB_Hold}, 32'd1);
    tick();
    expect_write("starve_after", 1'b1, 5'd4, 32'h44);
    check_eq("starve_after_hold", {31'd0, oWB_Hold}, 32'd0);
    tick();

    // $0 writes from both sources are dropped; aux drain still works
    do_reset();
    iQ1_Addr = 5'd0;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    expect_write("zero_n", 1'b0, 5'd0, 32'd0);
    check_eq("zero_ready", {31'd0, oAux_Ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    expect_write("zero_n1", 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_write("zero_drain", 1'b1, 5'd7, 32'h77);
    tick();

    // Same register twice, written in push order (push and pop overlap)
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hA1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hB2);
    expect_write("same_a", 1'b1, 5'd6, 32'hA1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_write("same_b", 1'b1, 5'd6, 32'hB2);
    tick();
    expect_write("same_end", 1'b0, 5'd0, 32'd0);
    tick();

    // Reset discards buffered entries and a push in the reset cycle
    iQ1_Addr = 5'd20;
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'hC0);
    tick();
    drive(1'b1, 5'd2, 32'h23, 1'b1, 5'd21, 32'hC1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'hC2);
    reset = 1'b1;
    expect_write("rst_mid", 1'b0, 5'd0, 32'd0);
    check_eq("rst_mid_busy", {31'd0, oQ1_Busy}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_write("rst_post0", 1'b0, 5'd0, 32'd0);
    check_eq("rst_post_ready", {31'd0, oAux_Ready}, 32'd1);
    check_eq("rst_post_busy", {31'd0, oQ1_Busy}, 32'd0);
    tick();
    expect_write("rst_post1", 1'b0, 5'd0, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
